// File: rtl/maxpool_relu_layer.sv
// maxpool_relu_layer: 2x2 signed max-pool followed by ReLU over KERNEL_COUNT square feature maps.
// One window per 6 cycles: four synchronous reads, a capture cycle and a single write.
module maxpool_relu_layer #(
    parameter int KERNEL_COUNT = 4,
    parameter int FM_SIZE      = 13,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = $clog2(KERNEL_COUNT*16+256)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done
);
    localparam int P = FM_SIZE / 2;

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE} state_t;
    state_t state, state_n;

    logic [15:0] k, pr, pc, k_n, pr_n, pc_n;
    logic [ADDR_W-1:0] src_q, dst_q, src_n, a_nxt, rd_off, wa;
    logic signed [DATA_W-1:0] acc, m, rd_s;
    logic accept, last, adv, row_end, map_end;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        accept  = start && (state == IDLE || state == DONE);
        row_end = pc == 16'(P-1);
        map_end = row_end && pr == 16'(P-1);
        last    = map_end && k == 16'(KERNEL_COUNT-1);
        adv     = state == WR && !last;
        state_n = state;
        case (state)
            IDLE, DONE: state_n = accept ? RD0 : state;
            RD0:        state_n = RD1;
            RD1:        state_n = RD2;
            RD2:        state_n = RD3;
            RD3:        state_n = CAP;
            CAP:        state_n = WR;
            WR:         state_n = last ? DONE : RD0;
            default:    state_n = IDLE;
        endcase
        pc_n  = accept ? '0 : adv ? (row_end ? '0 : pc + 16'd1) : pc;
        pr_n  = accept ? '0 : (adv && row_end) ? (map_end ? '0 : pr + 16'd1) : pr;
        k_n   = accept ? '0 : (adv && map_end) ? k + 16'd1 : k;
        src_n = accept ? src_base : src_q;
        // Address of the window being entered, so rd_addr is already valid in RD0.
        a_nxt = ADDR_W'(32'(src_n) + 32'(k_n)*FM_SIZE*FM_SIZE + 32'(pr_n)*2*FM_SIZE + 32'(pc_n)*2);
        rd_off = state_n == RD1 ? ADDR_W'(1) :
                 state_n == RD2 ? ADDR_W'(FM_SIZE) :
                 state_n == RD3 ? ADDR_W'(FM_SIZE+1) : '0;
        wa    = ADDR_W'(32'(dst_q) + 32'(k)*P*P + 32'(pr)*P + 32'(pc));
        rd_s  = signed'(rd_data);
        m     = rd_s > acc ? rd_s : acc;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            src_q   <= '0;
            dst_q   <= '0;
            k       <= '0;
            pr      <= '0;
            pc      <= '0;
            acc     <= '0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            src_q <= src_n;
            dst_q <= accept ? dst_base : dst_q;
            k     <= k_n;
            pr    <= pr_n;
            pc    <= pc_n;
            if (state_n inside {RD0, RD1, RD2, RD3}) rd_addr <= a_nxt + rd_off;
            acc   <= state == RD1 ? rd_s : (state inside {RD2, RD3, CAP}) ? m : acc;
            wr_en <= state == CAP;
            if (state == CAP) begin
                wr_addr <= wa;
                wr_data <= m[DATA_W-1] ? '0 : m;
            end
            done  <= state_n == DONE;
        end
endmodule

// File: tb/tb_maxpool_relu_layer.sv
// tb_maxpool_relu_layer: directed checks of the pooling layer with default parameters
// plus a small 4x4 single-map instance for the ramp case.
module tb_maxpool_relu_layer;
    localparam int AW = 9;
    localparam int NW = 4*6*6;

    logic clk = 0, rst = 1, start = 0;
    logic [AW-1:0] src_base = '0, dst_base = '0, rd_addr, wr_addr;
    logic [7:0] rd_data, wr_data;
    logic wr_en, done;

    logic r_start = 0;
    logic [AW-1:0] r_rd_addr, r_wr_addr;
    logic [7:0] r_rd_data, r_wr_data;
    logic r_wr_en, r_done;

    int checks = 0, failures = 0, wcount = 0;
    logic [7:0] mem [512];
    logic [7:0] rmem [512];
    logic [7:0] wmem [512];
    logic [AW-1:0] rd_c2, rd_c217;

    always #5 clk = ~clk;

    maxpool_relu_layer dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .done(done)
    );

    maxpool_relu_layer #(.KERNEL_COUNT(1), .FM_SIZE(4)) u_ramp (
        .clk(clk), .rst(rst), .start(r_start), .src_base(9'd0), .dst_base(9'd64),
        .rd_addr(r_rd_addr), .rd_data(r_rd_data), .wr_en(r_wr_en), .wr_addr(r_wr_addr),
        .wr_data(r_wr_data), .done(r_done)
    );

    always @(posedge clk) rd_data <= mem[rd_addr];
    always @(posedge clk) r_rd_data <= rmem[r_rd_addr];
    always @(posedge clk)
        if (wr_en) begin
            wmem[wr_addr] <= wr_data;
            wcount <= wcount + 1;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] win_a(input logic [AW-1:0] s, input int w);
        int k = w / 36, pr = (w % 36) / 6, pc = w % 6;
        return AW'(32'(s) + 32'(k*169 + 26*pr + 2*pc));
    endfunction

    function automatic logic [AW-1:0] offs(input int ph);
        return ph == 0 ? AW'(0) : ph == 1 ? AW'(1) : ph == 2 ? AW'(13) : AW'(14);
    endfunction

    function automatic logic [7:0] exp_val(input logic [AW-1:0] a);
        logic signed [7:0] mx = signed'(mem[a]);
        for (int i = 1; i < 4; i++)
            if (signed'(mem[a + offs(i)]) > mx) mx = signed'(mem[a + offs(i)]);
        return mx < 0 ? 8'd0 : mx;
    endfunction

    // Checks every cycle of a job against the address/write stream of the reference model.
    task automatic run_job(input logic [AW-1:0] s, input logic [AW-1:0] d, input int busy_c);
        int errs = 0, w0, w, ph;
        logic [AW-1:0] a;
        @(negedge clk);
        start = 1; src_base = s; dst_base = d;
        @(negedge clk);
        w0 = wcount;
        start = 0; src_base = ~s; dst_base = ~d;
        for (int c = 1; c <= 6*NW+1; c++) begin
            w = (c-1) / 6; ph = (c-1) % 6;
            if (c == 2) rd_c2 = rd_addr;
            if (c == 217) rd_c217 = rd_addr;
            if (c <= 6*NW) begin
                a = win_a(s, w);
                if (ph < 4 && rd_addr !== a + offs(ph)) errs++;
                if (wr_en !== (ph == 5)) errs++;
                if (ph == 5 && (wr_addr !== AW'(32'(d) + 32'(w)) || wr_data !== exp_val(a))) errs++;
                if (done !== 1'b0) errs++;
            end
            start = (c == busy_c);
            if (c == busy_c) begin src_base = 9'd5; dst_base = 9'd300; end
            if (c <= 6*NW) @(negedge clk);
        end
        start = 0;
        chk("done_after_busy", 32'(done), 32'd1);
        chk("stream_errors", errs, 0);
        chk("write_count", wcount - w0, NW);
    endtask

    initial begin
        int n, done_c, w0;
        logic [AW-1:0] ra [4];
        logic [7:0] rdv [4];
        for (int i = 0; i < 512; i++) begin
            mem[i] = 8'(i*37 + 11);
            rmem[i] = i < 16 ? 8'(i) : 8'd0;
            wmem[i] = 8'haa;
        end
        {mem[64], mem[65], mem[77], mem[78]} = {8'h80, 8'hff, 8'hfb, 8'hfe};
        {mem[66], mem[67], mem[79], mem[80]} = {8'h7f, 8'h80, 8'h00, 8'h00};
        {mem[68], mem[69], mem[81], mem[82]} = {8'hfd, 8'h04, 8'h04, 8'hfd};

        repeat (2) @(negedge clk);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        rst = 0;

        // Ramp on a 4x4 single map.
        @(negedge clk); r_start = 1;
        @(negedge clk); r_start = 0;
        n = 0; done_c = -1;
        for (int c = 1; c <= 40 && done_c < 0; c++) begin
            if (r_wr_en && n < 4) begin ra[n] = r_wr_addr; rdv[n] = r_wr_data; end
            if (r_wr_en) n++;
            if (r_done) done_c = c;
            @(negedge clk);
        end
        chk("ramp_writes", n, 4);
        chk("ramp_done_cycle", done_c, 25);
        for (int i = 0; i < 4; i++) chk("ramp_addr", 32'(ra[i]), 64 + i);
        chk("ramp_d0", 32'(rdv[0]), 5);
        chk("ramp_d1", 32'(rdv[1]), 7);
        chk("ramp_d2", 32'(rdv[2]), 13);
        chk("ramp_d3", 32'(rdv[3]), 15);

        // Default odd-size job with a busy start during RD2 of window 3.
        run_job(9'd64, 9'd0, 21);
        chk("relu_all_neg", 32'(wmem[0]), 0);
        chk("relu_extremes", 32'(wmem[1]), 127);
        chk("relu_mixed", 32'(wmem[2]), 4);
        chk("map1_base", 32'(rd_c217), 233);

        // Restart from DONE with wrapping bases.
        chk("done_before_restart", 32'(done), 1);
        run_job(9'd511, 9'd400, 0);
        chk("wrap_second_read", 32'(rd_c2), 0);

        // Reset during CAP of window 2, then a full job.
        @(negedge clk); start = 1; src_base = 9'd64; dst_base = 9'd0;
        @(negedge clk); start = 0; w0 = wcount;
        repeat (16) @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_rd_addr", 32'(rd_addr), 0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 0);
        chk("mid_rst_wr_data", 32'(wr_data), 0);
        chk("mid_rst_done", 32'(done), 0);
        @(negedge clk);
        chk("mid_rst_wr_en_held", 32'(wr_en), 0);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("mid_rst_writes", wcount - w0, 2);
        chk("idle_after_rst", 32'(done), 0);
        run_job(9'd200, 9'd10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
